// File: rtl/clk_div_sched_pkg.sv
// Shared types and reset defaults for the clk_div_sched divider controller.
package clk_div_sched_pkg;
  localparam int CFG_W    = 8;
  localparam int DEF_DIV  = 5;
  localparam int DEF_HIGH = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } cfg_t;
endpackage

// File: rtl/clk_div_cfg_slot.sv
// One-deep pending config slot: legality check, valid/ready handshake, error pulse.
// CLK_DIV_SCHED_ODD50_EN: odd ratios ignore cfg_high and take H=(N-1)/2.
module clk_div_cfg_slot
  import clk_div_sched_pkg::*;
#(
  parameter int W = CFG_W
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           cfg_valid,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  input  logic           apply,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic [2*W-1:0] pend_cfg
);
  logic         full, accept, legal;
  logic [W-1:0] eff_high;

  assign cfg_ready = !full;
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    legal    = (cfg_div >= W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
    eff_high = cfg_high;
`ifdef CLK_DIV_SCHED_ODD50_EN
    if (cfg_div[0]) begin
      legal    = (cfg_div >= W'(3));
      eff_high = (cfg_div - W'(1)) >> 1;
    end
`endif
  end

  // accept needs an empty slot and apply needs a full one, so they never coincide
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      full     <= 1'b0;
      cfg_err  <= 1'b0;
      pend_cfg <= '0;
    end else begin
      cfg_err <= accept && !legal;
      if (accept && legal) begin
        full     <= 1'b1;
        pend_cfg <= {cfg_div, eff_high};
      end else if (apply) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_sched.sv
// Programmable integer clock divider: IDLE/RUN/DRAIN sequencing, boundary-only config apply.
// CLK_DIV_SCHED_ODD50_EN: adds a falling-edge flop for 50% duty on odd ratios.
module clk_div_sched #(
  parameter int W        = clk_div_sched_pkg::CFG_W,
  parameter int DEF_DIV  = clk_div_sched_pkg::DEF_DIV,
  parameter int DEF_HIGH = clk_div_sched_pkg::DEF_HIGH
) (
  input  logic         rst,
  input  logic         clk_in,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  output logic         clk_out,
  output logic         running,
  output logic         period_start,
  output logic         cfg_err
);
  import clk_div_sched_pkg::*;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, div, high, pend_div, pend_high;
  logic [2*W-1:0] pend_cfg;
  logic           last, apply, pos;

  clk_div_cfg_slot #(.W(W)) u_slot (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .apply     (apply),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .pend_cfg  (pend_cfg)
  );

  assign {pend_div, pend_high} = pend_cfg;
  assign last    = (cnt == div - W'(1));
  assign apply   = !cfg_ready && ((state == IDLE) || last);
  assign running = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN:   if (en) state_nxt = RUN;
               else if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      div          <= W'(DEF_DIV);
      high         <= W'(DEF_HIGH);
      pos          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt          <= '0;
        pos          <= 1'b0;
        period_start <= 1'b0;
      end else begin
        cnt          <= last ? '0 : cnt + W'(1);
        pos          <= (cnt < high);
        period_start <= (cnt == '0);
      end
      // the output computed at this edge still uses the old H, so the period closes cleanly
      if (apply) begin
        div  <= pend_div;
        high <= pend_high;
      end
    end
  end

`ifdef CLK_DIV_SCHED_ODD50_EN
  logic odd_q, neg;

  // odd_q tags pos with the ratio of the period it belongs to
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) odd_q <= 1'b0;
    else      odd_q <= div[0];
  end

  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) neg <= 1'b0;
    else      neg <= pos & odd_q;
  end

  assign clk_out = pos | neg;
`else
  assign clk_out = pos;
`endif
endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed table, hand-written corner sequences, randomized run vs model.
module tb_clk_div_sched;
  import clk_div_sched_pkg::*;

`ifdef CLK_DIV_SCHED_ODD50_EN
  localparam bit O = 1'b1;
  localparam int BAD_D = 4, BAD_H = 4;
`else
  localparam bit O = 1'b0;
  localparam int BAD_D = 3, BAD_H = 3;
`endif

  logic       rst, clk_in, en, cfg_valid;
  logic [7:0] cfg_div, cfg_high;
  logic       cfg_ready, clk_out, running, period_start, cfg_err;

  int nvec = 0;
  int nerr = 0;

  clk_div_sched dut (
    .rst          (rst),
    .clk_in       (clk_in),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .clk_out      (clk_out),
    .running      (running),
    .period_start (period_start),
    .cfg_err      (cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  // Tracks the position inside the current output period and whether the
  // divider is on / winding down; outputs are derived from the rules directly.
  int   m_n, m_h, m_ph;
  bit   m_act, m_stop, m_pend;
  cfg_t m_pc;
  bit   m_pos, m_ppos, m_odd, m_podd, m_ps, m_err;

  function automatic bit legal(int d, int h);
`ifdef CLK_DIV_SCHED_ODD50_EN
    if (d % 2 == 1) return d >= 3;
`endif
    return d >= 2 && h >= 1 && h <= d - 1;
  endfunction

  function automatic int eff_h(int d, int h);
`ifdef CLK_DIV_SCHED_ODD50_EN
    if (d % 2 == 1) return (d - 1) / 2;
`endif
    return h;
  endfunction

  function automatic bit exp_clk();
`ifdef CLK_DIV_SCHED_ODD50_EN
    return m_pos | (m_ppos & m_podd);
`else
    return m_pos;
`endif
  endfunction

  task automatic model_reset();
    m_n = DEF_DIV; m_h = DEF_HIGH; m_ph = 0;
    m_act = 0; m_stop = 0; m_pend = 0; m_pc = '0;
    m_pos = 0; m_ppos = 0; m_odd = 0; m_podd = 0; m_ps = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit at_end, do_apply, np;
    int d, h;
    d = int'(cfg_div);
    h = int'(cfg_high);
    at_end   = m_act && (m_ph == m_n - 1);
    do_apply = m_pend && (!m_act || at_end);
    np    = m_pend;
    m_err = 0;
    if (cfg_valid && !m_pend) begin
      if (legal(d, h)) begin
        np   = 1;
        m_pc = '{div: 8'(d), high: 8'(eff_h(d, h))};
      end else m_err = 1;
    end
    m_ppos = m_pos;
    m_podd = m_odd;
    m_odd  = (m_n % 2 == 1);
    if (m_act) begin
      m_pos = (m_ph < m_h);
      m_ps  = (m_ph == 0);
      m_ph  = at_end ? 0 : m_ph + 1;
    end else begin
      m_pos = 0;
      m_ps  = 0;
    end
    if (!m_act) begin
      m_act = en;
      m_stop = 0;
    end else if (en) m_stop = 0;
    else if (m_stop && at_end) begin
      m_act = 0;
      m_stop = 0;
    end else m_stop = 1;
    if (do_apply) begin
      m_n = int'(m_pc.div);
      m_h = int'(m_pc.high);
      np  = 0;
    end
    m_pend = np;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, logic got, logic want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_clk_out",      clk_out,      exp_clk());
    chk("m_period_start", period_start, m_ps);
    chk("m_running",      running,      m_act);
    chk("m_cfg_ready",    cfg_ready,    !m_pend);
    chk("m_cfg_err",      cfg_err,      m_err);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    #2;
    chk_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit en, v;
    int d, h;
    bit clk, ps, run, rdy, err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit e, bit v, int d, int h, bit c, bit p, bit r, bit y, bit er);
    vec_t t;
    t.en = e; t.v = v; t.d = d; t.h = h;
    t.clk = c; t.ps = p; t.run = r; t.rdy = y; t.err = er;
    return t;
  endfunction

  initial begin
    int t0, t1, k;
    bit seen;

    tbl[0]  = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);  // IDLE -> RUN, cnt=0
    tbl[1]  = mk(1, 0, 0, 0,  1, 1, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0,  1, 0, 1, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0,  O, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0, 0,  1, 1, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0,  1, 0, 1, 1, 0);
    tbl[8]  = mk(1, 1, 4, 1,  O, 0, 1, 0, 0);  // accepted at cnt=2
    tbl[9]  = mk(1, 0, 0, 0,  0, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);  // applied at cnt=4 boundary
    tbl[11] = mk(1, 0, 0, 0,  1, 1, 1, 1, 0);
    tbl[12] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[13] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[15] = mk(1, 0, 0, 0,  1, 1, 1, 1, 0);
    tbl[16] = mk(1, 1, BAD_D, BAD_H, 0, 0, 1, 1, 1);  // rejected
    tbl[17] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[18] = mk(1, 0, 0, 0,  0, 0, 1, 1, 0);
    tbl[19] = mk(1, 0, 0, 0,  1, 1, 1, 1, 0);

    rst = 0; en = 0; cfg_valid = 0; cfg_div = '0; cfg_high = '0;
    model_reset();
    #3;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_period_start", period_start, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    #19 rst = 1;  // released between edges

    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].v;
      cfg_div = 8'(tbl[i].d); cfg_high = 8'(tbl[i].h);
      @(posedge clk_in);
      #2;
      chk($sformatf("tbl%0d_clk_out", i), clk_out, tbl[i].clk);
      chk($sformatf("tbl%0d_period_start", i), period_start, tbl[i].ps);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].run);
      chk($sformatf("tbl%0d_cfg_ready", i), cfg_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_cfg_err", i), cfg_err, tbl[i].err);
    end
    cfg_valid = 0;

    // async reset during the high phase
    rst = 0;
    #1;
    chk("arst_clk_out", clk_out, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_period_start", period_start, 1'b0);
    chk("arst_cfg_ready", cfg_ready, 1'b1);
    @(negedge clk_in);
    en = 1;
    model_reset();
    rst = 1;
    cyc();
    chk("restart_first_low", clk_out, 1'b0);
    cyc();
    chk("restart_first_high", clk_out, 1'b1);
    for (int i = 0; i < 6; i++) cyc();

    // drain from cnt=1 with N=5
    k = 0;
    while (m_ph != 1 && k < 20) begin
      cyc();
      k++;
    end
    chk("drain_sync", (m_ph == 1), 1'b1);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("drain_run%0d", i), running, 1'b1);
    end
    cyc();
    chk("drain_idle_running", running, 1'b0);
    chk("drain_idle_clk_out", clk_out, 1'b0);
    cyc();
    chk("idle_hold_clk_out", clk_out, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
      cfg_high  = ($urandom_range(0, 39) == 0) ? 8'd254 : 8'($urandom_range(0, 10));
      cyc();
    end

`ifdef CLK_DIV_SCHED_ODD50_EN
    // 50% duty on N=5: high time must be 2.5 source periods
    cfg_valid = 0;
    rst = 0;
    @(negedge clk_in);
    en = 1;
    model_reset();
    rst = 1;
    for (int i = 0; i < 8; i++) cyc();
    seen = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (clk_out == 1'b0) seen = 1;
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (clk_out == 1'b1) begin seen = 1; t0 = int'($time); end
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (clk_out == 1'b0) begin seen = 1; t1 = int'($time); end
    end
    nvec++;
    if (t1 - t0 != 25) begin
      nerr++;
      $display("FAIL odd50_high_time: got %0d want 25", t1 - t0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
